mips32_mem_arbiter: RTL and testbench

- Single-clock arbiter sharing one single-port, fixed-latency unified memory between the pipeline's instruction-fetch port (read-only) and its data port (LW/SW).
- The data port has priority over fetch.
- A streak limiter guarantees fetch progress under sustained load/store traffic.
- A halt input stops new grants. This lets the pipeline's HALTED condition quiesce memory cleanly.

---
 rtl/mips32_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mips32_mem_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_mem_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch port and the data port.
// Data wins arbitration, a streak limiter bounds fetch starvation, and halt blocks new grants.
module mips32_mem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  input  logic          halt,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT        = 4'(MEM_LAT);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  state_t          state_q, state_d;
  logic            owner_data_q, owner_data_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      streak_q, streak_d;
  logic            if_ack_q, if_ack_d;
  logic            d_ack_q, d_ack_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            busy_q, busy_d;

  logic start;
  logic grant_data;

  assign start      = !halt && (if_req || d_req);
  // Fetch only overrides a pending data request once the data streak has saturated.
  assign grant_data = d_req && !(if_req && (streak_q == STREAK_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_data_q <= 1'b0;
      cnt_q        <= '0;
      streak_q     <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_data_q <= owner_data_d;
      cnt_q        <= cnt_d;
      streak_q     <= streak_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == 4'd1) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every output is registered, so this block computes the value each output takes next cycle.
  always_comb begin
    owner_data_d = owner_data_q;
    cnt_d        = cnt_q;
    streak_d     = streak_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    busy_d       = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          owner_data_d = grant_data;
          mem_en_d     = 1'b1;
          if (grant_data) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            if (if_req) streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
            else        streak_d = '0;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr;
            streak_d   = '0;
          end
        end
      end
      ISSUE: cnt_d = LAT;
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (owner_data_q) begin
            d_ack_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end
      default: ;
    endcase
  end

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Bench for mips32_mem_arbiter: one instance at MEM_LAT=1 for most scenarios, one at MEM_LAT=3
// for reset during an access; expected read data and grant order go through queues.
module tb_mips32_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_if_q[$];
  logic [DW-1:0] exp_d_q[$];
  byte           exp_grant_q[$];

  logic          a_rst, a_if_req, a_d_req, a_d_we, a_halt;
  logic [AW-1:0] a_if_addr, a_d_addr, a_mem_addr;
  logic [DW-1:0] a_d_wdata, a_if_rdata, a_d_rdata, a_mem_wdata, a_mem_rdata;
  logic          a_if_ack, a_d_ack, a_mem_en, a_mem_we, a_busy;

  logic          b_rst, b_if_req, b_d_req, b_d_we, b_halt;
  logic [AW-1:0] b_if_addr, b_d_addr, b_mem_addr;
  logic [DW-1:0] b_d_wdata, b_if_rdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
  logic          b_if_ack, b_d_ack, b_mem_en, b_mem_we, b_busy;

  mips32_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .MAX_STREAK(4)) u_a (
    .clk(clk), .rst(a_rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_ack(a_d_ack), .d_rdata(a_d_rdata), .halt(a_halt),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mips32_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3), .MAX_STREAK(4)) u_b (
    .clk(clk), .rst(b_rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ack(b_d_ack), .d_rdata(b_d_rdata), .halt(b_halt),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  function automatic logic [DW-1:0] pat_a(input logic [AW-1:0] a);
    return (a == 10'd5) ? 32'h2000000A : (32'h5A000000 | 32'(a));
  endfunction

  function automatic logic [DW-1:0] pat_b(input logic [AW-1:0] a);
    return 32'hC0DE0000 | 32'(a);
  endfunction

  // Memory A: read data valid exactly one cycle after the mem_en cycle, garbage otherwise.
  bit [DW-1:0] mem_a [0:1023];
  bit          wr_a  [0:1023];
  always @(posedge clk) begin
    if (a_mem_en && a_mem_we) begin
      mem_a[a_mem_addr] <= a_mem_wdata;
      wr_a[a_mem_addr]  <= 1'b1;
    end
    a_mem_rdata <= (a_mem_en && !a_mem_we) ?
                   (wr_a[a_mem_addr] ? mem_a[a_mem_addr] : pat_a(a_mem_addr)) : 32'h0BAD0BAD;
  end

  // Memory B: read-only pattern, valid exactly three cycles after the mem_en cycle.
  logic [DW-1:0] b_p1, b_p2;
  always @(posedge clk) begin
    b_p1        <= (b_mem_en && !b_mem_we) ? pat_b(b_mem_addr) : 32'h0BAD0BAD;
    b_p2        <= b_p1;
    b_mem_rdata <= b_p2;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    a_rst = 1'b1; a_if_req = 0; a_d_req = 0; a_d_we = 0; a_halt = 0;
    a_if_addr = '0; a_d_addr = '0; a_d_wdata = '0;
    tick(); tick();
    a_rst = 1'b0;
  endtask

  // Drives one access on DUT A and reports what was observed; callers judge the result.
  task automatic a_access(input bit is_data, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, output int lat, output int n_en,
                          output bit en_we, output logic [AW-1:0] en_addr,
                          output logic [DW-1:0] en_wdata);
    lat = -1; n_en = 0; en_we = 0; en_addr = '0; en_wdata = '0;
    if (is_data) begin
      a_d_req = 1; a_d_we = we; a_d_addr = addr; a_d_wdata = wdata;
    end else begin
      a_if_req = 1; a_if_addr = addr;
    end
    for (int k = 0; k < 30 && lat < 0; k++) begin
      tick();
      if (a_mem_en) begin
        n_en++; en_we = a_mem_we; en_addr = a_mem_addr; en_wdata = a_mem_wdata;
      end
      if (is_data ? a_d_ack : a_if_ack) begin
        lat = k; a_d_req = 0; a_if_req = 0;
      end
    end
    a_d_req = 0; a_if_req = 0;
  endtask

  task automatic test_reset();
    reset_a();
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({a_if_ack, a_d_ack, a_mem_en, a_mem_we, a_busy} !== 5'b0 || a_if_rdata !== '0 ||
          a_d_rdata !== '0 || a_mem_addr !== '0 || a_mem_wdata !== '0) begin
        failures++;
        $display("FAIL reset_idle cycle %0d: ack/en/we/busy=%b if_rdata=%h d_rdata=%h addr=%h wdata=%h, required all zero",
                 k, {a_if_ack, a_d_ack, a_mem_en, a_mem_we, a_busy}, a_if_rdata, a_d_rdata,
                 a_mem_addr, a_mem_wdata);
      end
    end
  endtask

  task automatic test_single_fetch();
    int lat, n_en, extra;
    bit en_we;
    logic [AW-1:0] en_addr;
    logic [DW-1:0] en_wdata, exp;
    exp_if_q.push_back(32'h2000000A);
    a_access(1'b0, 1'b0, 10'd5, '0, lat, n_en, en_we, en_addr, en_wdata);
    exp = exp_if_q.pop_front();
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL fetch_latency: got %0d, required 2", lat); end
    checks++;
    if (a_if_rdata !== exp) begin
      failures++; $display("FAIL fetch_rdata: got %h, required %h", a_if_rdata, exp);
    end
    checks++;
    if (n_en !== 1 || en_we !== 1'b0 || en_addr !== 10'd5) begin
      failures++; $display("FAIL fetch_mem_strobe: n_en=%0d we=%b addr=%h, required 1 0 005", n_en, en_we, en_addr);
    end
    extra = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (a_mem_en || a_if_ack || a_d_ack) extra++;
    end
    checks++;
    if (extra !== 0 || a_if_rdata !== exp) begin
      failures++; $display("FAIL fetch_quiet_after: extra=%0d if_rdata=%h, required 0 %h", extra, a_if_rdata, exp);
    end
  endtask

  task automatic test_store_load();
    int lat, n_en;
    bit en_we;
    logic [AW-1:0] en_addr;
    logic [DW-1:0] en_wdata, exp;
    a_access(1'b1, 1'b1, 10'h3FF, 32'hDEADBEEF, lat, n_en, en_we, en_addr, en_wdata);
    checks++;
    if (lat !== 2 || n_en !== 1) begin
      failures++; $display("FAIL store_ack: lat=%0d n_en=%0d, required 2 1", lat, n_en);
    end
    checks++;
    if (en_we !== 1'b1 || en_addr !== 10'h3FF || en_wdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL store_mem: we=%b addr=%h wdata=%h, required 1 3ff deadbeef", en_we, en_addr, en_wdata);
    end
    checks++;
    if (a_d_rdata !== 32'h0) begin
      failures++; $display("FAIL store_keeps_d_rdata: got %h, required 00000000", a_d_rdata);
    end
    tick();
    exp_d_q.push_back(32'hDEADBEEF);
    a_access(1'b1, 1'b0, 10'h3FF, 32'h0, lat, n_en, en_we, en_addr, en_wdata);
    exp = exp_d_q.pop_front();
    checks++;
    if (lat !== 2 || en_we !== 1'b0 || n_en !== 1) begin
      failures++; $display("FAIL load_ack: lat=%0d we=%b n_en=%0d, required 2 0 1", lat, en_we, n_en);
    end
    checks++;
    if (a_d_rdata !== exp) begin
      failures++; $display("FAIL load_rdata: got %h, required %h", a_d_rdata, exp);
    end
    checks++;
    if (a_if_rdata !== 32'h2000000A) begin
      failures++; $display("FAIL if_rdata_held: got %h, required 2000000a", a_if_rdata);
    end
    tick();
    checks++;
    if (a_d_ack !== 1'b0 || a_d_rdata !== exp) begin
      failures++; $display("FAIL load_ack_pulse: ack=%b rdata=%h, required 0 %h", a_d_ack, a_d_rdata, exp);
    end
  endtask

  task automatic test_priority_starvation();
    int n_acks, last_ack;
    bit prev_en;
    byte got, expg;
    reset_a();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 4; j++) exp_grant_q.push_back("D");
      exp_grant_q.push_back("F");
    end
    a_if_addr = 10'h010; a_d_addr = 10'h020; a_d_we = 1'b0;
    a_if_req = 1'b1; a_d_req = 1'b1;
    n_acks = 0; last_ack = -1; prev_en = 1'b0;
    for (int k = 0; k < 100 && n_acks < 10; k++) begin
      tick();
      checks++;
      if (a_if_ack && a_d_ack) begin
        failures++; $display("FAIL ack_exclusive cycle %0d: if_ack=1 d_ack=1, required not both", k);
      end
      checks++;
      if (a_mem_en && prev_en) begin
        failures++; $display("FAIL mem_en_consecutive cycle %0d: got two strobes in a row, required gap", k);
      end
      prev_en = a_mem_en;
      if (a_if_ack || a_d_ack) begin
        got  = a_d_ack ? "D" : "F";
        expg = exp_grant_q.pop_front();
        checks++;
        if (got !== expg) begin
          failures++; $display("FAIL grant_order ack %0d: got %c, required %c", n_acks, got, expg);
        end
        checks++;
        if (a_d_ack ? (a_d_rdata !== pat_a(10'h020)) : (a_if_rdata !== pat_a(10'h010))) begin
          failures++; $display("FAIL stream_rdata ack %0d: d=%h if=%h, required d=%h if=%h", n_acks,
                               a_d_rdata, a_if_rdata, pat_a(10'h020), pat_a(10'h010));
        end
        if (last_ack >= 0) begin
          checks++;
          if (k - last_ack !== 4) begin
            failures++; $display("FAIL throughput ack %0d: spacing %0d, required 4", n_acks, k - last_ack);
          end
        end
        last_ack = k;
        n_acks++;
      end
    end
    a_if_req = 1'b0; a_d_req = 1'b0;
    checks++;
    if (n_acks !== 10) begin
      failures++; $display("FAIL stream_timeout: got %0d acks, required 10", n_acks);
    end
    exp_grant_q.delete();
    tick(); tick();
  endtask

  task automatic test_halt();
    int lat, n_en, dacks, iacks;
    logic [AW-1:0] first_addr;
    bit seen_en;
    logic [DW-1:0] exp;
    a_halt = 1'b0; a_d_we = 1'b0; a_d_addr = 10'h030; a_if_addr = 10'h011;
    a_d_req = 1'b1;
    exp_d_q.push_back(pat_a(10'h030));
    lat = -1;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      tick();
      if (k == 1) begin
        a_halt = 1'b1; a_if_req = 1'b1;
      end
      if (a_d_ack) lat = k;
    end
    exp = exp_d_q.pop_front();
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL halt_inflight_ack: lat=%0d, required 2", lat); end
    checks++;
    if (a_d_rdata !== exp) begin
      failures++; $display("FAIL halt_inflight_rdata: got %h, required %h", a_d_rdata, exp);
    end
    n_en = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (a_mem_en || a_if_ack || a_d_ack) n_en++;
    end
    checks++;
    if (n_en !== 0 || a_busy !== 1'b0) begin
      failures++; $display("FAIL halt_blocks: activity=%0d busy=%b, required 0 0", n_en, a_busy);
    end
    exp_d_q.push_back(pat_a(10'h030));
    exp_if_q.push_back(pat_a(10'h011));
    a_halt = 1'b0;
    seen_en = 1'b0; first_addr = '0; dacks = 0; iacks = 0;
    for (int k = 0; k < 40 && iacks == 0; k++) begin
      tick();
      if (a_mem_en && !seen_en) begin seen_en = 1'b1; first_addr = a_mem_addr; end
      if (a_d_ack) begin
        exp = exp_d_q.pop_front();
        checks++;
        if (a_d_rdata !== exp) begin
          failures++; $display("FAIL resume_d_rdata: got %h, required %h", a_d_rdata, exp);
        end
        a_d_req = 1'b0; dacks++;
      end
      if (a_if_ack) begin
        exp = exp_if_q.pop_front();
        checks++;
        if (a_if_rdata !== exp) begin
          failures++; $display("FAIL resume_if_rdata: got %h, required %h", a_if_rdata, exp);
        end
        a_if_req = 1'b0; iacks++;
      end
    end
    checks++;
    if (first_addr !== 10'h030 || dacks !== 1 || iacks !== 1) begin
      failures++; $display("FAIL resume_order: first_addr=%h dacks=%0d iacks=%0d, required 030 1 1",
                           first_addr, dacks, iacks);
    end
    a_d_req = 1'b0; a_if_req = 1'b0;
    exp_d_q.delete(); exp_if_q.delete();
    tick();
  endtask

  task automatic test_reset_mid();
    int acks, lat;
    logic [DW-1:0] exp;
    b_rst = 1'b1; b_if_req = 1'b0;
    tick(); tick();
    b_rst = 1'b0;
    b_if_addr = 10'd7; b_if_req = 1'b1;
    tick();
    checks++;
    if (b_mem_en !== 1'b1 || b_mem_addr !== 10'd7) begin
      failures++; $display("FAIL mid_issue: en=%b addr=%h, required 1 007", b_mem_en, b_mem_addr);
    end
    tick();
    b_rst = 1'b1; b_if_req = 1'b0;
    tick();
    b_rst = 1'b0;
    checks++;
    if (b_busy !== 1'b0 || b_if_ack !== 1'b0 || b_mem_en !== 1'b0 || b_if_rdata !== '0) begin
      failures++; $display("FAIL mid_reset_state: busy=%b ack=%b en=%b rdata=%h, required 0 0 0 0",
                           b_busy, b_if_ack, b_mem_en, b_if_rdata);
    end
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (b_if_ack || b_busy) acks++;
    end
    checks++;
    if (acks !== 0 || b_if_rdata !== '0) begin
      failures++; $display("FAIL mid_no_ack: activity=%0d rdata=%h, required 0 0", acks, b_if_rdata);
    end
    exp_if_q.push_back(pat_b(10'd9));
    b_if_addr = 10'd9; b_if_req = 1'b1;
    lat = -1;
    for (int k = 0; k < 30 && lat < 0; k++) begin
      tick();
      if (b_if_ack) begin lat = k; b_if_req = 1'b0; end
    end
    b_if_req = 1'b0;
    exp = exp_if_q.pop_front();
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL lat3_latency: got %0d, required 4", lat); end
    checks++;
    if (b_if_rdata !== exp) begin
      failures++; $display("FAIL lat3_rdata: got %h, required %h", b_if_rdata, exp);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b1; a_if_req = 0; a_d_req = 0; a_d_we = 0; a_halt = 0;
    a_if_addr = '0; a_d_addr = '0; a_d_wdata = '0;
    b_rst = 1'b1; b_if_req = 0; b_d_req = 0; b_d_we = 0; b_halt = 0;
    b_if_addr = '0; b_d_addr = '0; b_d_wdata = '0;
    test_reset();
    test_single_fetch();
    test_store_load();
    test_priority_starvation();
    test_halt();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
